// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman bit packer.
// Symbols are 1..NSYM; anything else is flagged, not encoded.
package huffman_pkg;

   localparam int NSYM       = 6;
   localparam int CODE_W_DEF = 8;
   localparam int BYTE_W_DEF = 8;
   localparam int ACC_W      = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } state_t;

   function automatic logic sym_legal(input logic [7:0] s);
      return (s >= 8'd1) && (s <= 8'(NSYM));
   endfunction

endpackage

// File: rtl/huffman_code_len.sv
// Mask to codeword length: index of highest set bit plus one.
// An all-zero mask gives length 0.
module huffman_code_len #(
   parameter int CODE_W = 8
) (
   input  logic [CODE_W-1:0] i_mask,
   output logic [3:0]        o_len
);

   always_comb begin
      o_len = '0;
      for (int i = 0; i < CODE_W; i++) begin
         if (i_mask[i]) o_len = 4'(i + 1);
      end
   end

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs per-symbol Huffman codewords MSB-first into bytes,
// zero-padding the tail and counting the encoded bits.
module huffman_bit_packer
   import huffman_pkg::*;
#(
   parameter int CODE_W = CODE_W_DEF,
   parameter int BYTE_W = BYTE_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_code_valid,
   input  logic [CODE_W-1:0] i_hc1,
   input  logic [CODE_W-1:0] i_hc2,
   input  logic [CODE_W-1:0] i_hc3,
   input  logic [CODE_W-1:0] i_hc4,
   input  logic [CODE_W-1:0] i_hc5,
   input  logic [CODE_W-1:0] i_hc6,
   input  logic [CODE_W-1:0] i_m1,
   input  logic [CODE_W-1:0] i_m2,
   input  logic [CODE_W-1:0] i_m3,
   input  logic [CODE_W-1:0] i_m4,
   input  logic [CODE_W-1:0] i_m5,
   input  logic [CODE_W-1:0] i_m6,
   input  logic              i_sym_valid,
   input  logic [7:0]        i_sym_data,
   input  logic              i_sym_last,
   output logic              o_sym_ready,
   output logic              o_byte_valid,
   output logic [BYTE_W-1:0] o_byte_data,
   output logic              o_byte_last,
   input  logic              i_byte_ready,
   output logic              o_done,
   output logic [CNT_W-1:0]  o_total_bits,
   output logic              o_err_sym
);

   logic [CODE_W-1:0] w_hc_in  [NSYM];
   logic [CODE_W-1:0] w_m_in   [NSYM];
   logic [3:0]        w_len_in [NSYM];
   logic [CODE_W-1:0] w_code_in[NSYM];

   logic [CODE_W-1:0] r_code [NSYM];
   logic [3:0]        r_len  [NSYM];

   state_t            r_state;
   logic [ACC_W-1:0]  r_acc;
   logic [4:0]        r_bit_cnt;
   logic [CNT_W-1:0]  r_total;
   logic              r_err;

   logic [CODE_W-1:0] w_code;
   logic [3:0]        w_len;
   logic [31:0]       w_lj_wide;
   logic [ACC_W-1:0]  w_ins;
   logic              w_legal;
   logic              w_sym_ready;
   logic              w_byte_valid;
   logic              w_byte_last;
   logic              w_sym_acc;
   logic              w_byte_acc;

   assign w_hc_in = '{i_hc1, i_hc2, i_hc3, i_hc4, i_hc5, i_hc6};
   assign w_m_in  = '{i_m1, i_m2, i_m3, i_m4, i_m5, i_m6};

   for (genvar g = 0; g < NSYM; g++) begin : g_len
      logic [31:0] w_lmask;
      huffman_code_len #(
         .CODE_W (CODE_W)
      ) u_len (
         .i_mask (w_m_in[g]),
         .o_len  (w_len_in[g])
      );
      // Keep only the low len bits so appends never spill.
      assign w_lmask      = (32'd1 << w_len_in[g]) - 32'd1;
      assign w_code_in[g] = w_hc_in[g] & w_lmask[CODE_W-1:0];
   end

   always_comb begin
      w_code = '0;
      w_len  = '0;
      for (int i = 0; i < NSYM; i++) begin
         if (i_sym_data == 8'(i + 1)) begin
            w_code = r_code[i];
            w_len  = r_len[i];
         end
      end
   end

   assign w_legal   = sym_legal(i_sym_data);
   assign w_lj_wide = {{(32-CODE_W){1'b0}}, w_code}
                      << (6'd16 - {2'b0, w_len});
   assign w_ins     = w_lj_wide[ACC_W-1:0] >> r_bit_cnt;

   assign w_sym_ready  = (r_state == RUN) && (r_bit_cnt < 5'd8);
   assign w_byte_valid =
      ((r_state == RUN) && (r_bit_cnt >= 5'd8)) ||
      ((r_state == FLUSH) && (r_bit_cnt != 5'd0));
   assign w_byte_last  = (r_state == FLUSH) &&
                         (r_bit_cnt != 5'd0) &&
                         (r_bit_cnt <= 5'd8);
   assign w_sym_acc    = i_sym_valid && w_sym_ready;
   assign w_byte_acc   = w_byte_valid && i_byte_ready;

   assign o_sym_ready  = w_sym_ready;
   assign o_byte_valid = w_byte_valid;
   assign o_byte_last  = w_byte_last;
   assign o_byte_data  = w_byte_valid ?
                         r_acc[ACC_W-1 -: BYTE_W] : '0;
   assign o_done       = (r_state == DONE);
   assign o_total_bits = r_total;
   assign o_err_sym    = r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_acc     <= '0;
         r_bit_cnt <= '0;
         r_total   <= '0;
         r_err     <= 1'b0;
         for (int i = 0; i < NSYM; i++) begin
            r_code[i] <= '0;
            r_len[i]  <= '0;
         end
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_code_valid) begin
                  for (int i = 0; i < NSYM; i++) begin
                     r_code[i] <= w_code_in[i];
                     r_len[i]  <= w_len_in[i];
                  end
                  r_acc     <= '0;
                  r_bit_cnt <= '0;
                  r_total   <= '0;
                  r_err     <= 1'b0;
                  r_state   <= RUN;
               end
            end
            RUN: begin
               if (w_sym_acc) begin
                  if (w_legal) begin
                     r_acc     <= r_acc | w_ins;
                     r_bit_cnt <= r_bit_cnt + {1'b0, w_len};
                     r_total   <= r_total + CNT_W'(w_len);
                  end else begin
                     r_err <= 1'b1;
                  end
                  if (i_sym_last) r_state <= FLUSH;
               end else if (w_byte_acc) begin
                  r_acc     <= r_acc << BYTE_W;
                  r_bit_cnt <= r_bit_cnt - 5'd8;
               end
            end
            FLUSH: begin
               if (r_bit_cnt == 5'd0) begin
                  r_state <= DONE;
               end else if (w_byte_acc) begin
                  r_acc <= r_acc << BYTE_W;
                  if (w_byte_last) begin
                     r_bit_cnt <= '0;
                     r_state   <= DONE;
                  end else begin
                     r_bit_cnt <= r_bit_cnt - 5'd8;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/huffman_bit_packer.md
Name: huffman_bit_packer

Overview:
- Downstream stage of the Huffman encoder.
- Latches the six codewords (HC1..HC6) and masks (M1..M6) when the encoder pulses code_valid.
- Re-reads the gray symbol stream and packs each symbol's variable-length codeword MSB-first into 8-bit bytes, with valid/ready backpressure on both sides.
- Zero-pads the final partial byte and reports the total encoded bit count.

Parameters:
CODE_W, 8, width of HCn/Mn; maximum codeword length
BYTE_W, 8, output byte width (fixed 8; parameter for readability only)
CNT_W, 16, width of total_bits counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
code_valid  in  1  one-cycle pulse: HC1..HC6/M1..M6 valid this cycle
HC1..HC6  in  CODE_W each  codeword, LSB-aligned
M1..M6  in  CODE_W each  mask, contiguous ones from LSB marking codeword bits
sym_valid  in  1  symbol present
sym_data  in  8  gray symbol, legal values 1..6
sym_last  in  1  qualifies final symbol of the stream
sym_ready  out  1  symbol accepted when sym_valid&sym_ready
byte_valid  out  1  packed byte present
byte_data  out  8  packed byte, first code bit in bit 7
byte_last  out  1  final byte of the stream
byte_ready  in  1  downstream accepts byte
done  out  1  one-cycle pulse at end of stream
total_bits  out  CNT_W  encoded bits accumulated this stream, padding excluded
err_sym  out  1  sticky: illegal symbol seen this stream

Behaviour:
- Reset (reset, synchronous, active-high; clock clk):
  - State IDLE; code tables, accumulator, bit_cnt, total_bits and err_sym cleared.
  - All outputs 0.
- Code length: len_n = position of highest set bit of Mn, plus 1 (0 if Mn==0). Codeword bits = HCn[len_n-1:0], emitted MSB first.
- Accumulator: 16 bits, left-justified; bit_cnt ranges 0..15.
- States:
  - IDLE: wait for code_valid. On code_valid, latch all 12 tables, clear total_bits/err_sym/accumulator, go RUN. Tables are retained otherwise.
  - RUN:
    - sym_ready = (bit_cnt < 8). byte_valid = (bit_cnt >= 8); the two are mutually exclusive, so no simultaneous accept and emit.
    - On accept of a legal symbol: append len bits; bit_cnt += len; total_bits += len (wraps at 2^CNT_W).
    - On accept of an illegal symbol (0 or >6): append nothing; set err_sym.
    - On byte handshake: byte_data = acc[15:8]; shift left 8; bit_cnt -= 8; byte_last=0.
    - If the accepted symbol has sym_last=1: go FLUSH next cycle.
  - FLUSH:
    - sym_ready=0.
    - bit_cnt > 8: byte_valid=1, byte_last=0.
    - 1 <= bit_cnt <= 8: byte_valid=1, byte_last=1, byte_data = top 8 bits with zero padding; on handshake go DONE.
    - bit_cnt == 0: go DONE with no byte. Any earlier byte was already emitted with byte_last=0.
  - DONE: done=1 for exactly one cycle, go IDLE. A new code_valid is required for the next stream.
- Latency: a byte becomes valid the cycle after the accept that makes bit_cnt >= 8.
- Backpressure: while byte_valid && !byte_ready, byte_data/byte_last hold stable and sym_ready stays 0.
- code_valid outside IDLE is ignored. sym_valid outside RUN is not accepted.
- Reset asserted mid-stream aborts immediately. No byte_last and no done are produced.

Decomposition:
- Package huffman_pkg holds:
  - NSYM=6
  - CODE_W/BYTE_W defaults
  - state enum {IDLE, RUN, FLUSH, DONE}
  - symbol-legal check function
- Sub-module huffman_code_len (combinational mask→length, CODE_W in, 4-bit out), instantiated six times at table load, storing lengths in registers.

Test Plan:
Codes used throughout, as (HCn, Mn) with resulting codeword:
- sym1 = (1, 0x01) → "1"
- sym2 = (1, 0x03) → "01"
- sym3 = (0, 0x07) → "000"
- sym4 = (2, 0x0F) → "0010"
- sym5 = (6, 0x1F) → "00110"
- sym6 = (7, 0x1F) → "00111"

Scenarios:
1. Stream 1,1,2,3 (last on 3), byte_ready=1 → single byte 0xD0 with byte_last=1; total_bits=7; done pulses once.
2. Eight sym1 (last on 8th) → single byte 0xFF with byte_last=1; no pad byte; total_bits=8.
3. Stream 5,6 (last on 6) → 0x31 (byte_last=0), then 0xC0 (byte_last=1); total_bits=10.
4. Scenario 3 with byte_ready low for 5 cycles on first byte → 0x31 held stable; sym_ready=0 throughout; output sequence unchanged.
5. Stream 1,0,9,1 (last on final 1) → err_sym=1; byte 0xC0 with byte_last=1; total_bits=2.
6. Reset asserted after two symbols of scenario 3, then fresh code_valid and scenario 1 → outputs match scenario 1 exactly; no spurious done or byte.
